// File: rtl/modcnt_pkg.sv
// Shared types for the up/down modulo counter: end-of-count modes and FSM states.
package modcnt_pkg;

  typedef enum logic [1:0] {
    WRAP    = 2'd0,
    SAT     = 2'd1,
    ONESHOT = 2'd2,
    RSVD    = 2'd3
  } mode_e;

  typedef enum logic {
    RUN  = 1'b0,
    DONE = 1'b1
  } state_e;

endpackage

// File: rtl/modcnt_updown.sv
// Parametrised up/down modulo counter with wrap/saturate/one-shot end-of-count,
// synchronous clear/load and a registered one-cycle terminal-count pulse.
module modcnt_updown
  import modcnt_pkg::*;
#(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [Width-1:0] data_i,
  input  logic             up_i,
  input  logic [1:0]       mode_i,
  input  logic [Width-1:0] max_i,
  output logic [Width-1:0] cnt_o,
  output logic             tc_o,
  output logic             done_o
);

  logic [Width-1:0] cnt_q, cnt_d;
  logic             tc_q, tc_d;
  logic             done_q, done_d;
  state_e           state_q, state_d;
  logic             at_term;
  mode_e            mode;

  assign mode = mode_e'(mode_i);

  // Next-state: clear beats load beats count; DONE freezes the count.
  always_comb begin
    cnt_d   = cnt_q;
    tc_d    = 1'b0;
    done_d  = done_q;
    state_d = state_q;
    at_term = up_i ? (cnt_q >= max_i) : (cnt_q == '0);

    if (clr_i) begin
      cnt_d   = '0;
      done_d  = 1'b0;
      state_d = RUN;
    end else if (load_i) begin
      cnt_d   = data_i;
      done_d  = 1'b0;
      state_d = RUN;
    end else if (en_i && (state_q == RUN)) begin
      if (!at_term) begin
        cnt_d = up_i ? (cnt_q + Width'(1)) : (cnt_q - Width'(1));
      end else begin
        tc_d = 1'b1;
        case (mode)
          SAT: cnt_d = cnt_q;
          ONESHOT: begin
            cnt_d   = cnt_q;
            state_d = DONE;
            done_d  = 1'b1;
          end
          // Reserved encoding behaves as WRAP.
          default: cnt_d = up_i ? '0 : max_i;
        endcase
      end
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q   <= '0;
      tc_q    <= 1'b0;
      done_q  <= 1'b0;
      state_q <= RUN;
    end else begin
      cnt_q   <= cnt_d;
      tc_q    <= tc_d;
      done_q  <= done_d;
      state_q <= state_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign tc_o   = tc_q;
  assign done_o = done_q;

endmodule

// File: tb/tb_modcnt_updown.sv
// Directed self-checking bench for modcnt_updown (Width 8 and Width 4 instances).
module tb_modcnt_updown;

  logic       clk_i = 1'b0;
  logic       rst_i;
  // Width 8 instance
  logic       en_i, clr_i, load_i, up_i;
  logic [1:0] mode_i;
  logic [7:0] data_i, max_i, cnt_o;
  logic       tc_o, done_o;
  // Width 4 instance
  logic       en4, clr4, load4, up4;
  logic [1:0] mode4;
  logic [3:0] data4, max4, cnt4;
  logic       tc4, done4;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  modcnt_updown #(.Width(8)) u8 (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .clr_i(clr_i), .load_i(load_i),
    .data_i(data_i), .up_i(up_i), .mode_i(mode_i), .max_i(max_i),
    .cnt_o(cnt_o), .tc_o(tc_o), .done_o(done_o)
  );

  modcnt_updown #(.Width(4)) u4 (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en4), .clr_i(clr4), .load_i(load4),
    .data_i(data4), .up_i(up4), .mode_i(mode4), .max_i(max4),
    .cnt_o(cnt4), .tc_o(tc4), .done_o(done4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic exp8(input string tag, input int c, input bit t, input bit d);
    chk({tag, ".cnt"}, 32'(cnt_o), 32'(c));
    chk({tag, ".tc"}, 32'(tc_o), 32'(t));
    chk({tag, ".done"}, 32'(done_o), 32'(d));
  endtask

  task automatic exp4(input string tag, input int c, input bit t);
    chk({tag, ".cnt"}, 32'(cnt4), 32'(c));
    chk({tag, ".tc"}, 32'(tc4), 32'(t));
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i = 1'b0;
    en_i = 0; clr_i = 0; load_i = 0; up_i = 1; mode_i = 2'd0; data_i = 0; max_i = 0;
    en4 = 0; clr4 = 0; load4 = 0; up4 = 1; mode4 = 2'd0; data4 = 0; max4 = 0;
    #12;
    exp8("reset", 0, 0, 0);
    exp4("reset4", 0, 0);

    // Wrap up, max 5
    max_i = 8'd5; up_i = 1; mode_i = 2'd0; en_i = 1;
    rst_i = 1'b1;
    step(); exp8("wrap1", 1, 0, 0);
    step(); exp8("wrap2", 2, 0, 0);
    step(); exp8("wrap3", 3, 0, 0);
    step(); exp8("wrap4", 4, 0, 0);
    step(); exp8("wrap5", 5, 0, 0);
    step(); exp8("wrap0", 0, 1, 0);
    step(); exp8("wrap1b", 1, 0, 0);

    // Down with saturate
    load_i = 1; data_i = 8'd3;
    step(); exp8("ld3", 3, 0, 0);
    load_i = 0; up_i = 0; mode_i = 2'd1;
    step(); exp8("sat2", 2, 0, 0);
    step(); exp8("sat1", 1, 0, 0);
    step(); exp8("sat0", 0, 0, 0);
    step(); exp8("sat0a", 0, 1, 0);
    step(); exp8("sat0b", 0, 1, 0);
    en_i = 0;
    step(); exp8("sat_dis", 0, 0, 0);

    // Down wrap reloads max
    en_i = 1; mode_i = 2'd0; max_i = 8'd5;
    step(); exp8("dwrap", 5, 1, 0);

    // One-shot
    max_i = 8'd252; mode_i = 2'd2; up_i = 1; load_i = 1; data_i = 8'd250;
    step(); exp8("os_ld", 250, 0, 0);
    load_i = 0;
    step(); exp8("os251", 251, 0, 0);
    step(); exp8("os252", 252, 0, 0);
    step(); exp8("os_term", 252, 1, 1);
    step(); exp8("os_hold", 252, 0, 1);
    en_i = 0; up_i = 0;
    step(); exp8("os_en0", 252, 0, 1);
    en_i = 1;
    step(); exp8("os_down", 252, 0, 1);
    mode_i = 2'd0;
    step(); exp8("os_wrapmode", 252, 0, 1);
    load_i = 1; data_i = 8'd10; up_i = 1; mode_i = 2'd2;
    step(); exp8("os_reload", 10, 0, 0);
    load_i = 0;
    step(); exp8("os_resume", 11, 0, 0);

    // Priority clear > load > count
    clr_i = 1; load_i = 1; en_i = 1; data_i = 8'h7F;
    step(); exp8("prio_clr", 0, 0, 0);
    clr_i = 0; en_i = 0;
    step(); exp8("prio_ld", 8'h7F, 0, 0);

    // Out-of-range load then wrap
    load_i = 1; data_i = 8'd200; max_i = 8'd10; mode_i = 2'd0; up_i = 1;
    step(); exp8("oor_ld", 200, 0, 0);
    load_i = 0; en_i = 1;
    step(); exp8("oor_wrap", 0, 1, 0);

    // Reserved mode behaves as WRAP
    mode_i = 2'd3; load_i = 1; data_i = 8'd10;
    step(); exp8("rsvd_ld", 10, 0, 0);
    load_i = 0;
    step(); exp8("rsvd_wrap", 0, 1, 0);

    // max 0: pulse every enabled cycle in both directions
    max_i = 8'd0; mode_i = 2'd0;
    step(); exp8("max0_up", 0, 1, 0);
    up_i = 0;
    step(); exp8("max0_dn", 0, 1, 0);

    // Async reset mid-cycle while tc and done are high
    up_i = 1; max_i = 8'd10; mode_i = 2'd2; load_i = 1; data_i = 8'd10;
    step(); exp8("ar_ld", 10, 0, 0);
    load_i = 0;
    step(); exp8("ar_term", 10, 1, 1);
    #2 rst_i = 1'b0;
    #1 exp8("ar_async", 0, 0, 0);
    mode_i = 2'd0;
    #1 rst_i = 1'b1;
    step(); exp8("ar_first", 1, 0, 0);
    en_i = 0;

    // Width 4: full-range wrap both directions
    max4 = 4'd15; up4 = 1; mode4 = 2'd0; load4 = 1; data4 = 4'd14;
    step(); exp4("w4_ld", 14, 0);
    load4 = 0; en4 = 1;
    step(); exp4("w4_15", 15, 0);
    step(); exp4("w4_0", 0, 1);
    up4 = 0;
    step(); exp4("w4_dn15", 15, 1);
    step(); exp4("w4_dn14", 14, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
